// File: rtl/cdec8_pkg.sv
// Shared types and encodings for the CDEC8 control unit: state codes, XBUS field
// codes, ALU ops, the ctrl word layout and small decode helpers.
package cdec8_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StF0   = 4'd1,
    StF1   = 4'd2,
    StF2   = 4'd3,
    StE0   = 4'd4,
    StE1   = 4'd5,
    StE2   = 4'd6,
    StE3   = 4'd7,
    StE4   = 4'd8,
    StHalt = 4'd9
  } state_e;

  // General registers A/B/C appear on the XBUS as {2'b00, reg_code}.
  localparam logic [3:0] XSRC_PC    = 4'b0000;
  localparam logic [3:0] XSRC_R     = 4'b0100;
  localparam logic [3:0] XSRC_RDR   = 4'b0101;
  localparam logic [3:0] XSRC_IPORT = 4'b1000;
  localparam logic [3:0] XSRC_NONE  = 4'b1111;

  localparam logic [3:0] XDST_PC    = 4'b0000;
  localparam logic [3:0] XDST_MAR   = 4'b0100;
  localparam logic [3:0] XDST_WDR   = 4'b0101;
  localparam logic [3:0] XDST_T     = 4'b0110;
  localparam logic [3:0] XDST_I     = 4'b0111;
  localparam logic [3:0] XDST_OPORT = 4'b1000;
  localparam logic [3:0] XDST_NONE  = 4'b1111;

  localparam logic [1:0] MMRW_NONE = 2'b00;
  localparam logic [1:0] MMRW_RD   = 2'b10;
  localparam logic [1:0] MMRW_WR   = 2'b01;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_HLT = 4'h1;
  localparam logic [3:0] OP_OUT = 4'h2;
  localparam logic [3:0] OP_IN  = 4'h3;
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_LD  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_JS  = 4'hB;
  localparam logic [3:0] OP_ADD = 4'hC;
  localparam logic [3:0] OP_SUB = 4'hD;
  localparam logic [3:0] OP_AND = 4'hE;
  localparam logic [3:0] OP_OR  = 4'hF;

  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_INC = 5'd5;

  typedef struct packed {
    logic [1:0] mmrw;
    logic       fwr;
    logic       rwr;
    logic [3:0] xdst;
    logic [4:0] aluop;
    logic [3:0] xsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP    = '{MMRW_NONE, 1'b0, 1'b0, XDST_NONE, ALU_NOP, XSRC_NONE};
  // First and second halves of a PC-addressed read (instruction or operand fetch).
  localparam ctrl_t CTRL_PC_INC = '{MMRW_NONE, 1'b0, 1'b1, XDST_MAR, ALU_INC, XSRC_PC};
  localparam ctrl_t CTRL_PC_RD  = '{MMRW_RD, 1'b0, 1'b0, XDST_PC, ALU_NOP, XSRC_R};

  function automatic ctrl_t ctrl_xfer(logic [3:0] src, logic [3:0] dst);
    ctrl_t c;
    c      = CTRL_NOP;
    c.xsrc = src;
    c.xdst = dst;
    return c;
  endfunction

  function automatic logic [4:0] alu_of(logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_NOP;
    endcase
  endfunction

  // An instruction whose used register field is 00 degrades to a NOP.
  function automatic logic instr_legal(logic [7:0] i);
    logic rd_ok, rs_ok;
    rd_ok = (i[3:2] != 2'b00);
    rs_ok = (i[1:0] != 2'b00);
    case (i[7:4])
      OP_OUT:                                return rs_ok;
      OP_IN, OP_LDI, OP_LD, OP_ST:           return rd_ok;
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: return rd_ok & rs_ok;
      default:                               return 1'b1;
    endcase
  endfunction

  function automatic state_e last_exec_state(logic [7:0] i);
    if (!instr_legal(i)) return StE0;
    case (i[7:4])
      OP_LD, OP_ST: return StE4;
      OP_LDI, OP_JMP, OP_JZ, OP_JC, OP_JS,
      OP_ADD, OP_SUB, OP_AND, OP_OR: return StE2;
      default: return StE0;
    endcase
  endfunction

endpackage

// File: rtl/cdec8_decode.sv
// Combinational ctrl-word decode from (state, instruction, flags).
module cdec8_decode
  import cdec8_pkg::*;
(
  input  logic [3:0]  st_i,
  input  logic [7:0]  instr_i,
  input  logic [2:0]  szcy_i,
  output logic [16:0] ctrl_o
);

  state_e     st;
  logic [3:0] op;
  logic [3:0] rd_code;
  logic [3:0] rs_code;
  logic       legal;
  logic       taken;
  ctrl_t      c;

  assign st      = state_e'(st_i);
  assign op      = instr_i[7:4];
  assign rd_code = {2'b00, instr_i[3:2]};
  assign rs_code = {2'b00, instr_i[1:0]};
  assign legal   = instr_legal(instr_i);
  assign ctrl_o  = c;

  // Branch condition select for JZ/JC/JS; flags are {S, Z, Cy}.
  always_comb begin
    case (op)
      OP_JZ:   taken = szcy_i[1];
      OP_JC:   taken = szcy_i[0];
      OP_JS:   taken = szcy_i[2];
      default: taken = 1'b0;
    endcase
  end

  // Per-state micro-op selection; anything not listed stays CTRL_NOP.
  always_comb begin
    c = CTRL_NOP;
    case (st)
      StF0: c = CTRL_PC_INC;
      StF1: c = CTRL_PC_RD;
      StF2: c = ctrl_xfer(XSRC_RDR, XDST_I);
      StE0: if (legal) begin
        case (op)
          OP_OUT: c = ctrl_xfer(rs_code, XDST_OPORT);
          OP_IN:  c = ctrl_xfer(XSRC_IPORT, rd_code);
          OP_MOV: c = ctrl_xfer(rs_code, rd_code);
          OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JC, OP_JS: c = CTRL_PC_INC;
          OP_ADD, OP_SUB, OP_AND, OP_OR: c = ctrl_xfer(rs_code, XDST_T);
          default: ;
        endcase
      end
      StE1: if (legal) begin
        case (op)
          OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JC, OP_JS: c = CTRL_PC_RD;
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            c.xsrc  = rd_code;
            c.aluop = alu_of(op);
            c.rwr   = 1'b1;
            c.fwr   = 1'b1;
          end
          default: ;
        endcase
      end
      StE2: if (legal) begin
        case (op)
          OP_LDI:                        c = ctrl_xfer(XSRC_RDR, rd_code);
          OP_LD, OP_ST:                  c = ctrl_xfer(XSRC_RDR, XDST_MAR);
          OP_JMP:                        c = ctrl_xfer(XSRC_RDR, XDST_PC);
          OP_JZ, OP_JC, OP_JS:           if (taken) c = ctrl_xfer(XSRC_RDR, XDST_PC);
          OP_ADD, OP_SUB, OP_AND, OP_OR: c = ctrl_xfer(XSRC_R, rd_code);
          default: ;
        endcase
      end
      StE3: if (legal) begin
        case (op)
          OP_LD:   c.mmrw = MMRW_RD;
          OP_ST:   c = ctrl_xfer(rd_code, XDST_WDR);
          default: ;
        endcase
      end
      StE4: if (legal) begin
        case (op)
          OP_LD:   c = ctrl_xfer(XSRC_RDR, rd_code);
          OP_ST:   c.mmrw = MMRW_WR;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cdec8_ctrl.sv
// CDEC8 hardwired control unit: fetch/execute state register and sequencing.
// Optional feature macro CDEC8_STEP_EN: run/step gating of instruction issue.
module cdec8_ctrl
  import cdec8_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  I,
  input  logic [2:0]  SZCy,
  input  logic        run,
  input  logic        step,
  output logic [16:0] ctrl,
  output logic [7:0]  state,
  output logic        halted,
  output logic        instr_done
);

  state_e      state_q, state_d;
  logic        last_cycle;
  logic        idle_go;
  state_e      after_instr;
  logic [16:0] dec_ctrl;

  cdec8_decode u_decode (
    .st_i    (state_q),
    .instr_i (I),
    .szcy_i  (SZCy),
    .ctrl_o  (dec_ctrl)
  );

`ifdef CDEC8_STEP_EN
  assign idle_go     = run | step;
  assign after_instr = run ? StF0 : StIdle;
`else
  logic unused_run_step;
  assign unused_run_step = run ^ step;
  assign idle_go         = 1'b1;
  assign after_instr     = StF0;
`endif

  // last_exec_state only ever returns an E-state, so equality implies execute phase.
  assign last_cycle = (state_q == last_exec_state(I));

  // Next-state sequencing through fetch and the instruction's execute states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: state_d = idle_go ? StF0 : StIdle;
      StF0:   state_d = StF1;
      StF1:   state_d = StF2;
      StF2:   state_d = StE0;
      StE0:   state_d = !last_cycle ? StE1 : (I[7:4] == OP_HLT) ? StHalt : after_instr;
      StE1:   state_d = last_cycle ? after_instr : StE2;
      StE2:   state_d = last_cycle ? after_instr : StE3;
      StE3:   state_d = last_cycle ? after_instr : StE4;
      StE4:   state_d = after_instr;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  assign ctrl       = reset ? CTRL_NOP : dec_ctrl;
  assign state      = {4'h0, state_q};
  assign halted     = (state_q == StHalt);
  assign instr_done = last_cycle & ~reset;

endmodule

// File: tb/tb_cdec8_ctrl.sv
// Scoreboard bench for cdec8_ctrl: stimulus pushes the per-cycle expected outputs
// from an instruction-level model; a negedge monitor pops and compares.
module tb_cdec8_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  I = 8'h00;
  logic [2:0]  SZCy = 3'b000;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [16:0] ctrl;
  logic [7:0]  state;
  logic        halted;
  logic        instr_done;

  cdec8_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .I          (I),
    .SZCy       (SZCy),
    .run        (run),
    .step       (step),
    .ctrl       (ctrl),
    .state      (state),
    .halted     (halted),
    .instr_done (instr_done)
  );

  always #5 clock = ~clock;

  // Field codes and ctrl layout {mmrw, fwr, rwr, xdst, aluop, xsrc}.
  localparam logic [3:0] S_PC = 4'h0, S_R = 4'h4, S_RDR = 4'h5, S_IPORT = 4'h8;
  localparam logic [3:0] D_PC = 4'h0, D_MAR = 4'h4, D_WDR = 4'h5, D_T = 4'h6, D_I = 4'h7;
  localparam logic [3:0] D_OPORT = 4'h8, NONE = 4'hF;
  localparam logic [4:0] A_NOP = 5'd0, A_INC = 5'd5;

  function automatic logic [16:0] w(logic [1:0] mm, logic f, logic r, logic [3:0] d,
                                    logic [4:0] a, logic [3:0] s);
    return {mm, f, r, d, a, s};
  endfunction

  function automatic logic [16:0] mv(logic [3:0] s, logic [3:0] d);
    return w(2'b00, 1'b0, 1'b0, d, A_NOP, s);
  endfunction

  localparam logic [16:0] NOPW = {2'b00, 1'b0, 1'b0, 4'hF, 5'd0, 4'hF};

  typedef struct packed {
    logic [16:0] ctrl;
    logic [7:0]  st;
    logic        done;
    logic        halt;
    logic [7:0]  tag;
  } exp_t;

  exp_t        sb[$];
  logic [16:0] ops[$];
  bit          halts;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        e;

  // Monitor: one expected entry per clock cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({ctrl, state, instr_done, halted} !== {e.ctrl, e.st, e.done, e.halt}) begin
        n_fail++;
        $display("FAIL cycle I=%h: got ctrl=%h state=%h done=%b halted=%b, want ctrl=%h state=%h done=%b halted=%b",
                 e.tag, ctrl, state, instr_done, halted, e.ctrl, e.st, e.done, e.halt);
      end
    end
  end

  function automatic exp_t ent(logic [16:0] c, logic [7:0] s, logic d, logic h);
    exp_t x;
    x.ctrl = c; x.st = s; x.done = d; x.halt = h; x.tag = I;
    return x;
  endfunction

  task automatic cyc(input exp_t x);
    sb.push_back(x);
`ifndef CDEC8_STEP_EN
    run  = 1'($urandom_range(0, 1));
    step = 1'($urandom_range(0, 1));
`endif
    @(posedge clock);
    #1;
  endtask

  // Instruction-level reference: the list of execute-phase ctrl words.
  task automatic model(input logic [7:0] ins, input logic [2:0] f);
    logic [3:0]  rd, rs;
    logic        rdv, rsv, tk;
    logic [16:0] fa, fb;
    rd  = {2'b00, ins[3:2]};
    rs  = {2'b00, ins[1:0]};
    rdv = ins[3:2] != 2'b00;
    rsv = ins[1:0] != 2'b00;
    fa  = w(2'b00, 1'b0, 1'b1, D_MAR, A_INC, S_PC);
    fb  = w(2'b10, 1'b0, 1'b0, D_PC, A_NOP, S_R);
    ops.delete();
    halts = 1'b0;
    case (ins[7:4])
      4'h1: begin ops.push_back(NOPW); halts = 1'b1; end
      4'h2: ops.push_back(rsv ? mv(rs, D_OPORT) : NOPW);
      4'h3: ops.push_back(rdv ? mv(S_IPORT, rd) : NOPW);
      4'h4: ops.push_back(rdv && rsv ? mv(rs, rd) : NOPW);
      4'h5: if (rdv) ops = {fa, fb, mv(S_RDR, rd)}; else ops.push_back(NOPW);
      4'h6: if (rdv) ops = {fa, fb, mv(S_RDR, D_MAR), w(2'b10, 1'b0, 1'b0, NONE, A_NOP, NONE),
                            mv(S_RDR, rd)};
            else ops.push_back(NOPW);
      4'h7: if (rdv) ops = {fa, fb, mv(S_RDR, D_MAR), mv(rd, D_WDR),
                            w(2'b01, 1'b0, 1'b0, NONE, A_NOP, NONE)};
            else ops.push_back(NOPW);
      4'h8: ops = {fa, fb, mv(S_RDR, D_PC)};
      4'h9, 4'hA, 4'hB: begin
        tk  = (ins[7:4] == 4'h9) ? f[1] : (ins[7:4] == 4'hA) ? f[0] : f[2];
        ops = {fa, fb, tk ? mv(S_RDR, D_PC) : NOPW};
      end
      4'hC, 4'hD, 4'hE, 4'hF:
        if (rdv && rsv)
          ops = {mv(rs, D_T), w(2'b00, 1'b1, 1'b1, NONE, 5'(ins[7:4] - 4'hB), rd), mv(S_R, rd)};
        else ops.push_back(NOPW);
      default: ops.push_back(NOPW);
    endcase
  endtask

  task automatic fetch3();
    cyc(ent(w(2'b00, 1'b0, 1'b1, D_MAR, A_INC, S_PC), 8'd1, 1'b0, 1'b0));
    cyc(ent(w(2'b10, 1'b0, 1'b0, D_PC, A_NOP, S_R), 8'd2, 1'b0, 1'b0));
    cyc(ent(mv(S_RDR, D_I), 8'd3, 1'b0, 1'b0));
  endtask

  task automatic run_instr(input logic [7:0] ins, input logic [2:0] f);
    int n;
    I    = ins;
    SZCy = f;
    model(ins, f);
    n = ops.size();
    fetch3();
    for (int k = 0; k < n; k++)
      cyc(ent(ops[k], 8'(4 + k), k == n - 1, 1'b0));
  endtask

  exp_t rst_e, idle_e;

  initial begin
    logic [7:0] ri;
    rst_e  = '0; rst_e.ctrl = NOPW;
    idle_e = rst_e;
`ifdef CDEC8_STEP_EN
    run = 1'b1;
`endif
    @(posedge clock); #1;
    cyc(rst_e);
    cyc(rst_e);
    reset = 1'b0;
    cyc(idle_e);
    // Directed: ALU, taken/untaken branch, store/load, port ops, illegal fields.
    run_instr(8'hC6, 3'b000);
    run_instr(8'hA0, 3'b001);
    run_instr(8'hA0, 3'b000);
    run_instr(8'h90, 3'b010);
    run_instr(8'hB0, 3'b011);
    run_instr(8'h78, 3'b000);
    run_instr(8'h6C, 3'b000);
    run_instr(8'h54, 3'b000);
    run_instr(8'h21, 3'b000);
    run_instr(8'h3C, 3'b000);
    run_instr(8'h49, 3'b000);
    run_instr(8'hC4, 3'b000);
    run_instr(8'h50, 3'b000);
    run_instr(8'h80, 3'b000);
    for (int n = 0; n < 60; n++) begin
      ri = 8'($urandom_range(0, 255));
      if (ri[7:4] == 4'h1) ri[7:4] = 4'h0;
      run_instr(ri, 3'($urandom_range(0, 7)));
    end
    // Reset during E3 of a store: no write, back to IDLE.
    I = 8'h78;
    model(8'h78, 3'b000);
    fetch3();
    for (int k = 0; k < 3; k++) cyc(ent(ops[k], 8'(4 + k), 1'b0, 1'b0));
    reset = 1'b1;
    cyc(ent(NOPW, 8'd7, 1'b0, 1'b0));
    cyc(rst_e);
    reset = 1'b0;
`ifdef CDEC8_STEP_EN
    run = 1'b0;
    cyc(idle_e);
    cyc(idle_e);
    step = 1'b1;
    cyc(idle_e);
    step = 1'b0;
    run_instr(8'h00, 3'b000);
    cyc(idle_e);
    cyc(idle_e);
    step = 1'b1;
    cyc(idle_e);
    step = 1'b0;
    run_instr(8'hC6, 3'b000);
    cyc(idle_e);
    run = 1'b1;
`endif
    cyc(idle_e);
    // Halt: parks with NOP ctrl until reset.
    run_instr(8'h10, 3'b000);
    for (int k = 0; k < 3; k++) begin
      I = 8'($urandom_range(0, 255));
      cyc(ent(NOPW, 8'd9, 1'b0, 1'b1));
    end
    reset = 1'b1;
    cyc(ent(NOPW, 8'd9, 1'b0, 1'b1));
    cyc(rst_e);
    @(negedge clock); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard-drain: got %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before 200000");
    $fatal(1, "bench timeout");
  end

endmodule
